// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and constants for the K&S processor.
//   decoded_instruction_type : instruction codes delivered by the decoder
//   ctrl_state_type          : sequencing states of control_unit
//   OP_*                     : ALU operation encodings driven on 'operation'
//   branch_taken()           : branch decision from instruction and flags
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_BRANCH,
      I_BZERO,
      I_BNZERO,
      I_BNEG,
      I_BNNEG,
      I_BOV,
      I_BNOV,
      I_HALT
   } decoded_instruction_type;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM_LOAD,
      S_HALT
   } ctrl_state_type;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   // Branch decision: unconditional branch always taken, conditional ones
   // follow the registered flags, anything else never branches.
   function automatic logic branch_taken(
      input decoded_instruction_type i_ins,
      input logic                    i_zero,
      input logic                    i_neg,
      input logic                    i_sovf
   );
      logic r_taken;
      case (i_ins)
         I_BRANCH: r_taken = 1'b1;
         I_BZERO:  r_taken = i_zero;
         I_BNZERO: r_taken = ~i_zero;
         I_BNEG:   r_taken = i_neg;
         I_BNNEG:  r_taken = ~i_neg;
         I_BOV:    r_taken = i_sovf;
         I_BNOV:   r_taken = ~i_sovf;
         default:  r_taken = 1'b0;
      endcase
      return r_taken;
   endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH / DECODE / EXEC / MEM_LOAD / HALT sequencer
// driving the data_path control inputs and the RAM write strobe.
// Parameters:
//   RAM_LATENCY        cycles from stable RAM address to valid read data (1..15)
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous reset, active-high (name kept from the
//                       processor top); also forces every strobe low
//   decoded_instruction instruction currently held in the IR
//   zero_op, neg_op, unsigned_overflow, signed_overflow  registered flags
//   branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
//   write_reg_enable, flags_reg_enable, ram_write_enable  datapath/RAM controls
//   halted              processor stopped in HALT
//   instr_count         retired-instruction counter (wraps at 16 bits)
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int RAM_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halted,
   output logic [15:0]             instr_count
);

   // Value of the wait counter in the final cycle of a RAM access.
   localparam logic [3:0] W_LAST = 4'(RAM_LATENCY - 1);

   ctrl_state_type r_state;
   ctrl_state_type w_next_state;
   logic [3:0]     r_wait_cnt;
   logic [15:0]    r_instr_count;

   logic       w_branch;
   logic       w_pc_enable;
   logic       w_ir_enable;
   logic       w_addr_sel;
   logic       w_c_sel;
   logic [1:0] w_operation;
   logic       w_write_reg_enable;
   logic       w_flags_reg_enable;
   logic       w_ram_write_enable;
   logic       w_halted;

   // No branch condition tests unsigned overflow; the flag is accepted only
   // so the port list matches the datapath flag set.
   logic w_unused_flag;
   assign w_unused_flag = unsigned_overflow;

   // State register, per-state wait counter and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state       <= S_FETCH;
         r_wait_cnt    <= 4'd0;
         r_instr_count <= 16'd0;
      end else begin
         r_state <= w_next_state;
         // Counter restarts on every state entry and only runs while
         // waiting on RAM.
         if (w_next_state != r_state) begin
            r_wait_cnt <= 4'd0;
         end else if (r_state == S_FETCH || r_state == S_MEM_LOAD) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
         end else begin
            r_wait_cnt <= 4'd0;
         end
         if (w_pc_enable) begin
            r_instr_count <= r_instr_count + 16'd1;
         end else begin
            r_instr_count <= r_instr_count;
         end
      end
   end

   // Next-state and Moore outputs from state, wait counter and instruction.
   always_comb begin
      w_next_state       = r_state;
      w_branch           = 1'b0;
      w_pc_enable        = 1'b0;
      w_ir_enable        = 1'b0;
      w_addr_sel         = 1'b0;
      w_c_sel            = 1'b0;
      w_operation        = OP_ADD;
      w_write_reg_enable = 1'b0;
      w_flags_reg_enable = 1'b0;
      w_ram_write_enable = 1'b0;
      w_halted           = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (r_wait_cnt == W_LAST) begin
               w_ir_enable  = 1'b1;
               w_next_state = S_DECODE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            case (decoded_instruction)
               I_HALT:  w_next_state = S_HALT;
               I_LOAD:  w_next_state = S_MEM_LOAD;
               default: w_next_state = S_EXEC;
            endcase
         end
         S_EXEC: begin
            w_pc_enable  = 1'b1;
            w_next_state = S_FETCH;
            w_branch     = branch_taken(decoded_instruction, zero_op, neg_op,
                                        signed_overflow);
            case (decoded_instruction)
               I_ADD, I_SUB, I_AND, I_OR: begin
                  case (decoded_instruction)
                     I_SUB:   w_operation = OP_SUB;
                     I_AND:   w_operation = OP_AND;
                     I_OR:    w_operation = OP_OR;
                     default: w_operation = OP_ADD;
                  endcase
                  w_write_reg_enable = 1'b1;
                  w_flags_reg_enable = 1'b1;
               end
               // MOVE is an OR of the source with itself; flags stay untouched.
               I_MOVE: begin
                  w_operation        = OP_OR;
                  w_write_reg_enable = 1'b1;
               end
               I_STORE: begin
                  w_addr_sel         = 1'b1;
                  w_ram_write_enable = 1'b1;
               end
               default: begin
                  w_operation = OP_ADD;
               end
            endcase
         end
         S_MEM_LOAD: begin
            w_addr_sel = 1'b1;
            if (r_wait_cnt == W_LAST) begin
               w_c_sel            = 1'b1;
               w_write_reg_enable = 1'b1;
               w_pc_enable        = 1'b1;
               w_next_state       = S_FETCH;
            end else begin
               w_next_state = S_MEM_LOAD;
            end
         end
         S_HALT: begin
            w_halted     = 1'b1;
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Reset gates every output low combinationally, so an access in flight
   // when reset arrives never issues its final strobe.
   assign branch           = w_branch           & ~rst_n;
   assign pc_enable        = w_pc_enable        & ~rst_n;
   assign ir_enable        = w_ir_enable        & ~rst_n;
   assign addr_sel         = w_addr_sel         & ~rst_n;
   assign c_sel            = w_c_sel            & ~rst_n;
   assign operation        = w_operation        & {2{~rst_n}};
   assign write_reg_enable = w_write_reg_enable & ~rst_n;
   assign flags_reg_enable = w_flags_reg_enable & ~rst_n;
   assign ram_write_enable = w_ram_write_enable & ~rst_n;
   assign halted           = w_halted           & ~rst_n;
   assign instr_count      = r_instr_count;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
   import k_and_s_pkg::*;

   // Output bit layout: {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0],
   //                     wre, fre, rwe, halted}
   typedef struct {
      decoded_instruction_type ins;
      logic                    z;
      logic                    n;
      logic                    v;
      logic                    uo;
      logic [10:0]             exp_exec;
   } vec_t;

   typedef struct {
      logic [10:0] o;
      string       tag;
   } sb_t;

   logic clk;
   logic rst_n;
   decoded_instruction_type decoded_instruction;
   logic zero_op, neg_op, unsigned_overflow, signed_overflow;

   logic        b1, pc1, ir1, as1, cs1, wre1, fre1, rwe1, h1;
   logic [1:0]  op1;
   logic [15:0] cnt1;
   logic        b3, pc3, ir3, as3, cs3, wre3, fre3, rwe3, h3;
   logic [1:0]  op3;
   logic [15:0] cnt3;

   logic [10:0] w_o1, w_o3;
   assign w_o1 = {b1, pc1, ir1, as1, cs1, op1, wre1, fre1, rwe1, h1};
   assign w_o3 = {b3, pc3, ir3, as3, cs3, op3, wre3, fre3, rwe3, h3};

   control_unit #(.RAM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
      .signed_overflow(signed_overflow), .branch(b1), .pc_enable(pc1),
      .ir_enable(ir1), .addr_sel(as1), .c_sel(cs1), .operation(op1),
      .write_reg_enable(wre1), .flags_reg_enable(fre1),
      .ram_write_enable(rwe1), .halted(h1), .instr_count(cnt1)
   );

   control_unit #(.RAM_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
      .signed_overflow(signed_overflow), .branch(b3), .pc_enable(pc3),
      .ir_enable(ir3), .addr_sel(as3), .c_sel(cs3), .operation(op3),
      .write_reg_enable(wre3), .flags_reg_enable(fre3),
      .ram_write_enable(rwe3), .halted(h3), .instr_count(cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic sel3    = 1'b0;
   int   m_count = 0;
   sb_t  sb[$];
   vec_t vecs[20];
   int   n_vecs = 0;

   function automatic logic [10:0] mk(input logic b, pc, ir, as_, cs,
                                      input logic [1:0] op,
                                      input logic wre, fre, rwe, h);
      return {b, pc, ir, as_, cs, op, wre, fre, rwe, h};
   endfunction

   function automatic logic [10:0] act_o();
      return sel3 ? w_o3 : w_o1;
   endfunction

   function automatic logic [15:0] act_cnt();
      return sel3 ? cnt3 : cnt1;
   endfunction

   task automatic add(input decoded_instruction_type ins, input logic z, n,
                      v, uo, input logic [10:0] e);
      vecs[n_vecs].ins      = ins;
      vecs[n_vecs].z        = z;
      vecs[n_vecs].n        = n;
      vecs[n_vecs].v        = v;
      vecs[n_vecs].uo       = uo;
      vecs[n_vecs].exp_exec = e;
      n_vecs++;
   endtask

   task automatic push(input logic [10:0] o, input string tag);
      sb_t e;
      e.o   = o;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // FETCH (L cycles, ir_enable in the last) followed by DECODE.
   task automatic push_fetch_decode(input int lat);
      for (int k = 0; k < lat; k++)
         push(mk(0, 0, (k == lat - 1), 0, 0, 2'b00, 0, 0, 0, 0), "fetch");
      push(11'd0, "decode");
   endtask

   // Pop one expectation per cycle; called at a negedge with inputs set.
   task automatic drain();
      sb_t e;
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_tests++;
         if (act_o() !== e.o) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b", e.tag, act_o(), e.o);
         end
         n_tests++;
         if (act_cnt() !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", e.tag, act_cnt(),
                     m_count);
         end
         if (e.o[9]) m_count++;
         @(negedge clk);
      end
   endtask

   // Assert reset for 3 edges, checking strobes are forced low, then release.
   task automatic do_reset(input string tag);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (act_o() !== 11'd0) begin
         n_fail++;
         $display("FAIL %s forced: outputs got %b expected 0", tag, act_o());
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (act_o() !== 11'd0 || act_cnt() !== 16'd0) begin
            n_fail++;
            $display("FAIL %s hold: outputs got %b cnt %0d expected 0/0", tag,
                     act_o(), act_cnt());
         end
      end
      rst_n   = 1'b0;
      m_count = 0;
   endtask

   task automatic set_in(input decoded_instruction_type ins, input logic z, n,
                         v, uo);
      decoded_instruction = ins;
      zero_op             = z;
      neg_op              = n;
      signed_overflow     = v;
      unsigned_overflow   = uo;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [10:0] tk, nt;
      tk = mk(1, 1, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
      nt = mk(0, 1, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
      add(I_ADD,    0, 0, 0, 0, mk(0, 1, 0, 0, 0, OP_ADD, 1, 1, 0, 0));
      add(I_SUB,    0, 0, 0, 0, mk(0, 1, 0, 0, 0, OP_SUB, 1, 1, 0, 0));
      add(I_AND,    0, 0, 0, 0, mk(0, 1, 0, 0, 0, OP_AND, 1, 1, 0, 0));
      add(I_OR,     0, 0, 0, 0, mk(0, 1, 0, 0, 0, OP_OR,  1, 1, 0, 0));
      add(I_MOVE,   0, 0, 0, 0, mk(0, 1, 0, 0, 0, OP_OR,  1, 0, 0, 0));
      add(I_STORE,  0, 0, 0, 0, mk(0, 1, 0, 1, 0, OP_ADD, 0, 0, 1, 0));
      add(I_BRANCH, 0, 0, 0, 0, tk);
      add(I_NOP,    1, 1, 1, 1, nt);
      add(I_BZERO,  1, 0, 0, 0, tk);
      add(I_BZERO,  0, 1, 1, 1, nt);
      add(I_BNZERO, 0, 0, 0, 0, tk);
      add(I_BNZERO, 1, 0, 0, 0, nt);
      add(I_BNEG,   0, 1, 0, 0, tk);
      add(I_BNEG,   1, 0, 1, 1, nt);
      add(I_BNNEG,  0, 0, 0, 0, tk);
      add(I_BNNEG,  0, 1, 0, 0, nt);
      add(I_BOV,    0, 0, 1, 0, tk);
      add(I_BOV,    1, 1, 0, 1, nt);
      add(I_BNOV,   0, 0, 0, 0, tk);
      add(I_BNOV,   0, 0, 1, 0, nt);

      rst_n = 1'b1;
      set_in(I_NOP, 0, 0, 0, 0);
      @(negedge clk);

      // L=1: table of single instructions, back to back.
      sel3 = 1'b0;
      do_reset("reset_l1");
      for (int i = 0; i < n_vecs; i++) begin
         set_in(vecs[i].ins, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].uo);
         push_fetch_decode(1);
         push(vecs[i].exp_exec, $sformatf("exec_%s_%0d", vecs[i].ins.name(), i));
         drain();
      end

      // HALT: stays halted with no strobes, reset exits it.
      set_in(I_HALT, 0, 0, 0, 0);
      push_fetch_decode(1);
      for (int i = 0; i < 20; i++)
         push(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1), "halt");
      drain();
      do_reset("reset_halt");
      set_in(I_ADD, 0, 0, 0, 0);
      push_fetch_decode(1);
      push(mk(0, 1, 0, 0, 0, OP_ADD, 1, 1, 0, 0), "exec_after_halt");
      drain();

      // L=3: LOAD timing, then an ALU op.
      sel3 = 1'b1;
      do_reset("reset_l3");
      set_in(I_LOAD, 0, 0, 0, 0);
      push_fetch_decode(3);
      push(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "mem_load1");
      push(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "mem_load2");
      push(mk(0, 1, 0, 1, 1, 2'b00, 1, 0, 0, 0), "mem_load3");
      set_in(I_LOAD, 0, 0, 0, 0);
      drain();
      set_in(I_SUB, 0, 0, 0, 0);
      push_fetch_decode(3);
      push(mk(0, 1, 0, 0, 0, OP_SUB, 1, 1, 0, 0), "exec_sub_l3");
      drain();
      set_in(I_STORE, 0, 0, 0, 0);
      push_fetch_decode(3);
      push(mk(0, 1, 0, 1, 0, OP_ADD, 0, 0, 1, 0), "exec_store_l3");
      drain();

      // Reset in the final MEM_LOAD cycle: write strobe suppressed, FETCH next.
      set_in(I_LOAD, 0, 0, 0, 0);
      push_fetch_decode(3);
      push(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "midload1");
      push(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0), "midload2");
      drain();
      do_reset("reset_midload");
      set_in(I_NOP, 0, 0, 0, 0);
      push_fetch_decode(3);
      push(mk(0, 1, 0, 0, 0, OP_ADD, 0, 0, 0, 0), "exec_nop_after_reset");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencing FSM for the K&S processor. Drives every control input of `data_path` and the RAM write strobe through fetch, decode and execute phases, using the decoded instruction and the registered flags. Also provides a halt indication and a retired-instruction counter. Sits beside `data_path` inside the processor top.

## Interface
Parameters:
- RAM_LATENCY, 1: cycles from a RAM address becoming stable to read data being valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  synchronous reset, active-high: 1 resets the block on the next rising edge of clk
- decoded_instruction  in  decoded_instruction_type  instruction currently held in the IR
- zero_op, neg_op, unsigned_overflow, signed_overflow  in  1 each  registered flags from the datapath
- branch  out  1  PC loads the instruction address field instead of PC+1
- pc_enable  out  1  PC update strobe
- ir_enable  out  1  IR capture strobe
- addr_sel  out  1  RAM address select: 0 = PC, 1 = instruction address field
- c_sel  out  1  register write source: 0 = ALU output, 1 = RAM data_in
- operation  out  2  ALU operation: 00 ADD, 01 AND, 10 OR, 11 SUB
- write_reg_enable  out  1  register-file write strobe
- flags_reg_enable  out  1  flags-register capture strobe
- ram_write_enable  out  1  RAM write strobe, one cycle
- halted  out  1  processor is stopped in HALT
- instr_count  out  16  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM_LOAD, HALT.
- Outputs are Moore-style, derived from state, wait counter and decoded_instruction. Any output not named for a state is 0.
- **FETCH**
  - Drives addr_sel=0.
  - Waits RAM_LATENCY cycles using wait_cnt.
  - Asserts ir_enable in the last wait cycle, then goes to DECODE.
- **DECODE** (one cycle, no strobes)
  - I_HALT goes to HALT.
  - I_LOAD goes to MEM_LOAD.
  - Every other instruction, including I_NOP and unknown codes, goes to EXEC.
- **EXEC** (one cycle, always asserts pc_enable, returns to FETCH)
  - ADD/SUB/AND/OR: operation per encoding, c_sel=0, write_reg_enable=1, flags_reg_enable=1.
  - MOVE: operation=10 (OR, with a_addr equal to b_addr), c_sel=0, write_reg_enable=1, flags_reg_enable=0.
  - STORE: addr_sel=1, ram_write_enable=1.
  - BRANCH: branch=1.
  - Conditional branches set branch to the condition: BZERO uses zero_op, BNZERO uses !zero_op, BNEG uses neg_op, BNNEG uses !neg_op, BOV uses signed_overflow, BNOV uses !signed_overflow.
  - NOP: pc_enable only.
- **MEM_LOAD**
  - Drives addr_sel=1 and waits RAM_LATENCY cycles.
  - In the last cycle: c_sel=1, write_reg_enable=1, pc_enable=1, then FETCH.
  - flags_reg_enable is not asserted.
- **HALT**
  - halted=1, no strobes.
  - Stays in HALT until reset.
- **Flags:** branch conditions use flags latched by an earlier ALU instruction. The flags are never updated in the same cycle they are evaluated.
- **instr_count:** increments by 1 on every cycle where pc_enable=1 and wraps 0xFFFF to 0x0000. HALT is not counted.

## Timing
- **Reset:** with rst_n=1 at a rising edge, the block enters FETCH with wait_cnt=0 and instr_count=0.
- **Reset values:** while rst_n=1, every strobe output (pc_enable, ir_enable, write_reg_enable, flags_reg_enable, ram_write_enable, branch) and halted are forced to 0 combinationally. addr_sel=0, c_sel=0, operation=00.
- **Reset mid-operation:**
  - An in-flight load or store is abandoned and no write strobe is issued.
  - Reset also exits HALT.
- **Latency, with L = RAM_LATENCY:**
  - ALU, MOVE, STORE, branch and NOP: L+2 cycles.
  - LOAD: 2L+1 cycles.
  - HALT: reaches HALT L+1 cycles after entering FETCH.
- **First fetch:** at most one FETCH begins per instruction. The first fetch after reset release starts on the cycle following the release edge.
- **Wait counter:** width 4 bits, reset to 0 on every state entry.
- **Strobe widths:** every strobe is exactly one cycle wide. Asserting pc_enable together with write_reg_enable in the same cycle is legal.

## Structure
- `k_and_s_pkg` holds the `decoded_instruction_type` enum (I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT).
- The package also gains:
  - the control state enum `ctrl_state_type`;
  - ALU operation constants OP_ADD=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_SUB=2'b11.
- Single module `control_unit`. No sub-modules: one state register, one wait counter and one instr_count register.

## Test plan
- **Reset:** hold rst_n=1 for 3 cycles, then release. All strobes stay 0 during reset, instr_count=0, and ir_enable first pulses in FETCH (cycle 1 after release when L=1).
- **ADD, L=1:** decoded_instruction=I_ADD. Cycles go FETCH(ir_enable), DECODE, EXEC with operation=00, write_reg_enable=1, flags_reg_enable=1, pc_enable=1; instr_count goes 0 to 1.
- **LOAD, L=3:** ir_enable on cycle 3; MEM_LOAD holds addr_sel=1 for 3 cycles; write_reg_enable, c_sel=1 and pc_enable all appear on cycle 7.
- **Conditional branches:** I_BZERO with zero_op=1 gives branch=1 and pc_enable=1 in EXEC. With zero_op=0 it gives branch=0 and pc_enable=1. Repeat for BNEG/BNNEG and BOV/BNOV.
- **HALT:** I_HALT leads to halted=1 and no further strobes for 20 cycles. Asserting rst_n=1 then returns to FETCH with halted=0.
- **Mid-load reset:** assert rst_n during MEM_LOAD with L=3. No write_reg_enable is seen, and the next state is FETCH.
